// File: rtl/subterranean_squeezer.sv
// Output-side controller for the Subterranean 2.0 duplex: loads a state, runs blank
// rounds, then squeezes 32-bit words out through a valid/ready stream.

module subterranean_round (
  input  logic [256:0] a,
  input  logic [32:0]  din,
  output logic [256:0] o,
  output logic [31:0]  dout
);
  localparam int N = 257;

  // Position of duplex/extract lane j is 176^j mod 257 (176 = 12^4).
  function automatic int extract_pos(input int j);
    int r;
    r = 1;
    for (int k = 0; k < j; k++) r = (r * 176) % N;
    return r;
  endfunction

  function automatic int inject_lane(input int idx);
    int r;
    int res;
    r   = 1;
    res = -1;
    for (int j = 0; j < 33; j++) begin
      if (r == idx && res < 0) res = j;
      r = (r * 176) % N;
    end
    return res;
  endfunction

  logic [N-1:0] chi;
  logic [N-1:0] theta;
  logic [N-1:0] pi_s;
  logic [N-1:0] inj;

  genvar i;
  genvar j;

  // chi with iota folded into bit 0, then theta and pi.
  for (i = 0; i < N; i++) begin : g_step
    if (i == 0) begin : g_iota
      assign chi[i] = ~(a[i] ^ (~a[(i + 1) % N] & a[(i + 2) % N]));
    end else begin : g_chi
      assign chi[i] = a[i] ^ (~a[(i + 1) % N] & a[(i + 2) % N]);
    end
    assign theta[i] = chi[i] ^ chi[(i + 3) % N] ^ chi[(i + 8) % N];
    assign pi_s[i]  = theta[(12 * i) % N];
  end

  for (i = 0; i < N; i++) begin : g_inj
    localparam int LANE = inject_lane(i);
    if (LANE >= 0) begin : g_on
      assign inj[i] = din[LANE];
    end else begin : g_off
      assign inj[i] = 1'b0;
    end
  end

  assign o = pi_s ^ inj;

  for (j = 0; j < 32; j++) begin : g_ext
    localparam int P = extract_pos(j);
    assign dout[j] = a[P] ^ a[N - P];
  end
endmodule

module subterranean_squeezer #(
  parameter int BLANK_ROUNDS = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [256:0]         load_state,
  input  logic [CNT_WIDTH-1:0] load_num_words,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic [31:0]          dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy,
  output logic                 done
);
  localparam int BW = (BLANK_ROUNDS < 1) ? 1 : $clog2(BLANK_ROUNDS + 1);
  localparam logic [BW-1:0]        BLANK_INIT = BW'(BLANK_ROUNDS);
  localparam logic [BW-1:0]        BLANK_ONE  = BW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SQUEEZE,
    S_DRAIN
  } fsm_t;

  fsm_t                 fsm_q, fsm_d;
  logic [256:0]         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [BW-1:0]        blank_q, blank_d;
  logic [31:0]          dout_d;
  logic                 dout_valid_d;
  logic                 done_d;

  logic [256:0] round_o;
  logic [31:0]  round_dout;

  subterranean_round u_round (
    .a    (state_q),
    .din  (33'h000000001),
    .o    (round_o),
    .dout (round_dout)
  );

  assign load_ready = (fsm_q == S_IDLE);
  assign busy       = (fsm_q != S_IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    fsm_d        = fsm_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    blank_d      = blank_q;
    dout_d       = dout;
    dout_valid_d = dout_valid;
    done_d       = 1'b0;

    unique case (fsm_q)
      S_IDLE: begin
        if (load_valid) begin
          state_d = load_state;
          cnt_d   = load_num_words;
          blank_d = BLANK_INIT;
          fsm_d   = (BLANK_ROUNDS == 0) ? S_SQUEEZE : S_BLANK;
        end
      end
      S_BLANK: begin
        state_d = round_o;
        blank_d = blank_q - BLANK_ONE;
        if (blank_q <= BLANK_ONE) fsm_d = S_SQUEEZE;
      end
      S_SQUEEZE: begin
        if (cnt_q == '0) begin
          // The last word may be consumed on this same edge.
          if (dout_ready) dout_valid_d = 1'b0;
          fsm_d = S_DRAIN;
        end else if (!dout_valid || dout_ready) begin
          dout_d       = round_dout;
          dout_valid_d = 1'b1;
          state_d      = round_o;
          cnt_d        = cnt_q - CNT_ONE;
        end
      end
      S_DRAIN: begin
        if (!dout_valid || dout_ready) begin
          dout_valid_d = 1'b0;
          done_d       = 1'b1;
          fsm_d        = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      state_q    <= '0;
      cnt_q      <= '0;
      blank_q    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      done       <= done_d;
    end
  end
endmodule
